// File: rtl/vigna_mem_responder_pkg.sv
// vigna_mem_responder_pkg: shared FSM encodings and constants for the vigna memory responder
package vigna_mem_responder_pkg;
    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_WAIT     = 2'd1;
    localparam logic [1:0]  ST_RESP     = 2'd2;
    localparam logic [31:0] ERR_WORD    = 32'hDEADBEEF;
    localparam int          MIN_LATENCY = 1;
endpackage

// File: rtl/vigna_mem_port_ctrl.sv
// vigna_mem_port_ctrl: per-port valid/ready FSM with programmable latency and request capture
// Ports: clk, resetn (sync, active-low), i_valid, i_req (address/payload),
//        o_fire (array access happens on this edge), o_req (request in effect), o_ready.
module vigna_mem_port_ctrl
    import vigna_mem_responder_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_valid,
    input  logic [W-1:0] i_req,
    output logic         o_fire,
    output logic [W-1:0] o_req,
    output logic         o_ready
);
    localparam int LAT = (LATENCY < MIN_LATENCY) ? MIN_LATENCY : LATENCY;
    localparam int CW  = $clog2(LAT) + 1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_req;
    logic          w_in_wait;

    assign w_in_wait = (r_state == ST_WAIT);
    // Outside WAIT a request is being accepted this edge, so the live inputs are the request.
    assign o_req     = w_in_wait ? r_req : i_req;
    assign o_fire    = resetn && i_valid && (w_in_wait ? (r_cnt == CW'(1)) : (LAT == 1));
    assign o_ready   = (r_state == ST_RESP);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
        end else if (w_in_wait) begin
            r_state <= !i_valid ? ST_IDLE : (r_cnt == CW'(1)) ? ST_RESP : ST_WAIT;
            r_cnt   <= r_cnt - 1'b1;
        end else if (i_valid) begin
            r_state <= (LAT == 1) ? ST_RESP : ST_WAIT;
            r_cnt   <= CW'(LAT - 1);
            r_req   <= i_req;
        end else begin
            r_state <= ST_IDLE;
        end
    end
endmodule

// File: rtl/vigna_mem_responder.sv
// vigna_mem_responder: dual-port (fetch read-only, data read/write) memory target for the vigna core
module vigna_mem_responder
  import vigna_mem_responder_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter int    I_LATENCY  = 1,
  parameter int    D_LATENCY  = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata
`ifdef VIGNA_MEM_BOUNDS_EN
  ,
  output logic        bus_err
`endif
);
  logic [31:0]           r_mem [1 << ADDR_WIDTH];
  logic [31:0]           r_i_rdata, r_d_rdata;
  logic                  w_i_fire, w_d_fire, w_i_oob, w_d_oob, w_unused;
  logic [31:0]           w_i_addr, w_d_addr, w_d_wdata;
  logic [3:0]            w_d_wstrb;
  logic [67:0]           w_d_req;
  logic [ADDR_WIDTH-1:0] w_i_idx, w_d_idx;
  vigna_mem_port_ctrl #(.LATENCY(I_LATENCY), .W(32)) u_i_ctrl (
    .clk    (clk),
    .resetn (resetn),
    .i_valid(i_valid),
    .i_req  (i_addr),
    .o_fire (w_i_fire),
    .o_req  (w_i_addr),
    .o_ready(i_ready)
  );
  vigna_mem_port_ctrl #(.LATENCY(D_LATENCY), .W(68)) u_d_ctrl (
    .clk    (clk),
    .resetn (resetn),
    .i_valid(d_valid),
    .i_req  ({d_wstrb, d_wdata, d_addr}),
    .o_fire (w_d_fire),
    .o_req  (w_d_req),
    .o_ready(d_ready)
  );
  assign {w_d_wstrb, w_d_wdata, w_d_addr} = w_d_req;
  assign w_i_idx = w_i_addr[ADDR_WIDTH+1:2];
  assign w_d_idx = w_d_addr[ADDR_WIDTH+1:2];
`ifdef VIGNA_MEM_BOUNDS_EN
  logic r_bus_err;
  assign w_i_oob  = |w_i_addr[31:ADDR_WIDTH+2];
  assign w_d_oob  = |w_d_addr[31:ADDR_WIDTH+2];
  assign w_unused = ^{w_i_addr[1:0], w_d_addr[1:0]};
  assign bus_err  = r_bus_err;
  always_ff @(posedge clk) begin
    if (!resetn) r_bus_err <= 1'b0;
    else         r_bus_err <= r_bus_err | (w_i_fire & w_i_oob) | (w_d_fire & w_d_oob);
  end
`else
  assign w_i_oob  = 1'b0;
  assign w_d_oob  = 1'b0;
  assign w_unused = ^{w_i_addr[31:ADDR_WIDTH+2], w_i_addr[1:0], w_d_addr[31:ADDR_WIDTH+2], w_d_addr[1:0]};
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_i_fire) r_i_rdata <= w_i_oob ? ERR_WORD : r_mem[w_i_idx];
      if (w_d_fire) r_d_rdata <= w_d_oob ? ERR_WORD : r_mem[w_d_idx];
    end
  end
  always_ff @(posedge clk) begin
    if (w_d_fire && !w_d_oob)
      for (int k = 0; k < 4; k++)
        if (w_d_wstrb[k]) r_mem[w_d_idx][8*k +: 8] <= w_d_wdata[8*k +: 8];
  end
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
endmodule
